// File: rtl/mem_uart_dump.sv
// Memory-to-UART dump engine: reads a run of 32-bit words from data memory and
// streams each one out little-endian, one byte per txclk strobe.
module mem_uart_dump (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [7:0]  word_count,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [7:0]  txdata,
    output logic        txclk,
    input  logic        txready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        SEND = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] addr_r;
    logic [7:0]  remaining_r;
    logic [31:0] word_r;
    logic [1:0]  idx_r;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    // Dump sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= IDLE;
            addr_r      <= 32'd0;
            remaining_r <= 8'd0;
            word_r      <= 32'd0;
            idx_r       <= 2'd0;
            mem_read    <= 1'b0;
            mem_addr    <= 32'd0;
            txdata      <= 8'd0;
            txclk       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            txclk <= 1'b0;
            done  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        addr_r      <= {start_addr[31:2], 2'b00};
                        remaining_r <= word_count;
                        busy        <= 1'b1;
                        if (word_count == 8'd0) begin
                            state_r <= FIN;
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= {start_addr[31:2], 2'b00};
                            state_r  <= REQ;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        word_r   <= mem_rdata;
                        idx_r    <= 2'd0;
                        mem_read <= 1'b0;
                        state_r  <= SEND;
                    end else begin
                        state_r <= REQ;
                    end
                end
                SEND: begin
                    if (txready) begin
                        txdata  <= byte_sel(word_r, idx_r);
                        txclk   <= 1'b1;
                        state_r <= GAP;
                    end else begin
                        state_r <= SEND;
                    end
                end
                // txready is deliberately not looked at here: the UART gets a cycle to drop it.
                GAP: begin
                    if (idx_r != 2'd3) begin
                        idx_r   <= idx_r + 2'd1;
                        state_r <= SEND;
                    end else if (remaining_r > 8'd1) begin
                        remaining_r <= remaining_r - 8'd1;
                        addr_r      <= addr_r + 32'd4;
                        mem_addr    <= addr_r + 32'd4;
                        mem_read    <= 1'b1;
                        state_r     <= REQ;
                    end else begin
                        state_r <= FIN;
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    mem_read <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_uart_dump.sv
// Scoreboard bench for mem_uart_dump: stimulus pushes expected reads, bytes and
// done latencies; negedge monitors pop and compare.
module tb_mem_uart_dump;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'd0;
    logic [7:0]  word_count = 8'd0;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [7:0]  txdata;
    logic        txclk;
    logic        txready = 1'b1;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_addr[$];
    logic [7:0]  exp_bytes[$];
    int          exp_lat[$];

    int cyc = 0;
    int busy_rise = 0;
    int tx_count = 0;
    int done_cnt = 0;
    int rd_idx = 0;
    int stall_word = -1;
    int wait_cnt = 0;
    logic prev_busy = 1'b0;
    logic prev_txclk = 1'b0;

    mem_uart_dump dut (
        .clk(clk), .nrst(nrst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .txdata(txdata), .txclk(txclk),
        .txready(txready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0000_0040: mem_fn = 32'hDEAD_BEEF;
            32'h0000_0100: mem_fn = 32'h1122_3344;
            32'h0000_0104: mem_fn = 32'h5566_7788;
            32'h0000_0108: mem_fn = 32'h99AA_BBCC;
            32'hFFFF_FFFC: mem_fn = 32'hCAFE_F00D;
            32'h0000_0000: mem_fn = 32'h0BAD_F00D;
            default:       mem_fn = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        exp_bytes.push_back(b0);
        exp_bytes.push_back(b1);
        exp_bytes.push_back(b2);
        exp_bytes.push_back(b3);
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [7:0] n);
        @(negedge clk);
        start_addr = a;
        word_count = n;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done_cnt > base) break;
        end
        if (k == 3000) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done, expected a done pulse");
        end
        @(negedge clk);
        chk("addr_queue_empty", exp_addr.size(), 32'd0);
        chk("byte_queue_empty", exp_bytes.size(), 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_bytes(input int target);
        int k;
        for (k = 0; k < 500; k++) begin
            @(posedge clk);
            #2;
            if (tx_count >= target) break;
        end
        if (k == 500) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_timeout: got %0d bytes, expected %0d", tx_count, target);
        end
    endtask

    // Memory responder: acks after a per-read delay and checks the read address.
    always @(negedge clk) begin
        if (mem_read) begin
            if (wait_cnt >= ((rd_idx == stall_word) ? 3 : 0)) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
                n_checks++;
                if (exp_addr.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_read: got addr %08h, expected no read", mem_addr);
                end else begin
                    logic [31:0] ea;
                    ea = exp_addr.pop_front();
                    if (mem_addr !== ea) begin
                        n_errors++;
                        $display("FAIL read_addr: got %08h expected %08h", mem_addr, ea);
                    end
                end
                rd_idx++;
                wait_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // UART and done monitor.
    always @(negedge clk) begin
        cyc++;
        if (busy && !prev_busy) busy_rise = cyc;
        prev_busy = busy;
        if (txclk) begin
            n_checks++;
            if (prev_txclk) begin
                n_errors++;
                $display("FAIL txclk_consecutive: got txclk high twice, expected a gap");
            end
            tx_count++;
            n_checks++;
            if (exp_bytes.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_byte: got %02h, expected no strobe", txdata);
            end else begin
                logic [7:0] eb;
                eb = exp_bytes.pop_front();
                if (txdata !== eb) begin
                    n_errors++;
                    $display("FAIL txdata: got %02h expected %02h", txdata, eb);
                end
            end
        end
        prev_txclk = txclk;
        if (done) begin
            done_cnt++;
            n_checks++;
            if (exp_lat.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: got done, expected none");
            end else begin
                int el;
                el = exp_lat.pop_front();
                if (el >= 0 && (cyc - busy_rise) != el) begin
                    n_errors++;
                    $display("FAIL done_latency: got %0d expected %0d", cyc - busy_rise, el);
                end
            end
        end
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_txclk", {31'd0, txclk}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_txdata", {24'd0, txdata}, 32'd0);
        nrst = 1'b1;

        // single word
        exp_addr.push_back(32'h0000_0040);
        push_bytes(8'hEF, 8'hBE, 8'hAD, 8'hDE);
        exp_lat.push_back(10);
        base = done_cnt;
        pulse_start(32'h0000_0040, 8'd1);
        wait_done(base);

        // multi-word, unaligned start address
        exp_addr.push_back(32'h0000_0100);
        exp_addr.push_back(32'h0000_0104);
        exp_addr.push_back(32'h0000_0108);
        push_bytes(8'h44, 8'h33, 8'h22, 8'h11);
        push_bytes(8'h88, 8'h77, 8'h66, 8'h55);
        push_bytes(8'hCC, 8'hBB, 8'hAA, 8'h99);
        exp_lat.push_back(28);
        base = done_cnt;
        pulse_start(32'h0000_0103, 8'd3);
        wait_done(base);

        // same run with a txready stall before byte 2 and a slow ack on word 2
        exp_addr.push_back(32'h0000_0100);
        exp_addr.push_back(32'h0000_0104);
        exp_addr.push_back(32'h0000_0108);
        push_bytes(8'h44, 8'h33, 8'h22, 8'h11);
        push_bytes(8'h88, 8'h77, 8'h66, 8'h55);
        push_bytes(8'hCC, 8'hBB, 8'hAA, 8'h99);
        exp_lat.push_back(-1);
        rd_idx = 0;
        stall_word = 1;
        base = done_cnt;
        pulse_start(32'h0000_0100, 8'd3);
        wait_bytes(tx_count + 1);
        txready = 1'b0;
        repeat (5) @(posedge clk);
        #2 txready = 1'b1;
        wait_done(base);
        stall_word = -1;

        // zero words
        exp_lat.push_back(1);
        base = done_cnt;
        pulse_start(32'h0000_0200, 8'd0);
        wait_done(base);

        // address wrap
        exp_addr.push_back(32'hFFFF_FFFC);
        exp_addr.push_back(32'h0000_0000);
        push_bytes(8'h0D, 8'hF0, 8'hFE, 8'hCA);
        push_bytes(8'h0D, 8'hF0, 8'hAD, 8'h0B);
        exp_lat.push_back(19);
        base = done_cnt;
        pulse_start(32'hFFFF_FFFE, 8'd2);
        wait_done(base);

        // start while busy is ignored
        exp_addr.push_back(32'h0000_0040);
        push_bytes(8'hEF, 8'hBE, 8'hAD, 8'hDE);
        exp_lat.push_back(10);
        base = done_cnt;
        pulse_start(32'h0000_0040, 8'd1);
        repeat (2) @(negedge clk);
        pulse_start(32'h0000_0100, 8'd5);
        wait_done(base);
        repeat (20) @(negedge clk);

        // reset after the first byte of a word
        exp_addr.push_back(32'h0000_0100);
        exp_addr.push_back(32'h0000_0104);
        push_bytes(8'h44, 8'h33, 8'h22, 8'h11);
        push_bytes(8'h88, 8'h77, 8'h66, 8'h55);
        exp_lat.push_back(19);
        pulse_start(32'h0000_0100, 8'd2);
        wait_bytes(tx_count + 1);
        nrst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mem_read", {31'd0, mem_read}, 32'd0);
        chk("abort_txclk", {31'd0, txclk}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_txdata", {24'd0, txdata}, 32'd0);
        exp_addr.delete();
        exp_bytes.delete();
        exp_lat.delete();
        base = done_cnt;
        repeat (4) @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, base);

        exp_addr.push_back(32'h0000_0040);
        push_bytes(8'hEF, 8'hBE, 8'hAD, 8'hDE);
        exp_lat.push_back(10);
        base = done_cnt;
        pulse_start(32'h0000_0041, 8'd1);
        wait_done(base);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
